// File: rtl/training_sequencer_pkg.sv
// Shared types and constants for the training sequencer: FSM states and
// indices/widths of the backward handshake streams.
package training_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FW_REQ,
        S_FW_W,
        S_FW_Z,
        S_BW
    } seq_state_e;

    localparam int BW_STREAM_NUM      = 4;
    localparam int BW_LAYER           = 0;
    localparam int BW_SAMPLE          = 1;
    localparam int BW_Z               = 2;
    localparam int BW_ZPREV           = 3;
    localparam int SAMPLE_COUNT_WIDTH = 16;

endpackage

// File: rtl/training_sequencer_bw_stream_reg.sv
// Valid hold register for one backward stream: raised by load, dropped the
// cycle after its own handshake; done_o says this stream no longer blocks the layer.
module bw_stream_reg (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic ready_i,
    output logic valid_o,
    output logic done_o
);

    logic valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign done_o  = !valid_q || ready_i;

endmodule

// File: rtl/training_sequencer.sv
// Training sequencer: pushes one sample forward through every layer, then streams
// per-layer backward data, last layer first. Optional SAMPLE_COUNT_EN adds sample_count.
//
// state    | meaning
// IDLE     | waiting for a training sample
// FW_REQ   | requesting forward weights for layer l
// FW_W     | passing weights through to the neuron bank
// FW_Z     | waiting for layer l output, stored into buffer l+1
// BW       | backward streams for layer l outstanding
module training_sequencer
    import training_sequencer_pkg::*;
#(
    parameter int NEURON_NUM          = 4,
    parameter int NEURON_OUTPUT_WIDTH = 10,
    parameter int ACTIVATION_WIDTH    = 9,
    parameter int WEIGHT_CELL_WIDTH   = 16,
    parameter int LAYER_ADDR_WIDTH    = 2,
    parameter int LAYER_MAX           = 1
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0]              x_in,
    input  logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]                 y_in,
    input  logic                                                   in_valid,
    output logic                                                   in_ready,
    input  logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0]              z_in,
    input  logic                                                   z_in_valid,
    output logic                                                   z_in_ready,
    output logic [LAYER_ADDR_WIDTH-1:0]                            layer_fw,
    output logic                                                   layer_fw_valid,
    input  logic                                                   layer_fw_ready,
    input  logic [NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH-1:0]     weights,
    input  logic                                                   weights_valid,
    output logic                                                   weights_ready,
    output logic [NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH-1:0]     w_out,
    output logic                                                   w_out_valid,
    input  logic                                                   w_out_ready,
    output logic [LAYER_ADDR_WIDTH-1:0]                            layer_bw,
    output logic                                                   layer_bw_valid,
    input  logic                                                   layer_bw_ready,
    output logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]                 sample,
    output logic                                                   sample_valid,
    input  logic                                                   sample_ready,
    output logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0]              z,
    output logic                                                   z_valid,
    input  logic                                                   z_ready,
    output logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0]              z_prev,
    output logic                                                   z_prev_valid,
    input  logic                                                   z_prev_ready,
`ifdef SAMPLE_COUNT_EN
    output logic [SAMPLE_COUNT_WIDTH-1:0]                          sample_count,
`endif
    output logic                                                   busy
);

    localparam int ZW = NEURON_NUM * NEURON_OUTPUT_WIDTH;
    localparam int SW = NEURON_NUM * ACTIVATION_WIDTH;
    localparam logic [LAYER_ADDR_WIDTH-1:0] L_MAX = LAYER_ADDR_WIDTH'(LAYER_MAX);
    localparam logic [LAYER_ADDR_WIDTH-1:0] L_ONE = LAYER_ADDR_WIDTH'(1);

    seq_state_e                  state_q;
    logic [LAYER_ADDR_WIDTH-1:0] l_q;
    logic [ZW-1:0]               zbuf_q [0:LAYER_MAX+1];
    logic [SW-1:0]               target_q;
    logic [ZW-1:0]               z_sel, zp_sel;
    logic                        z_fire, bw_adv, bw_enter, bw_next;
    logic [BW_STREAM_NUM-1:0]    bw_load, bw_ready, bw_valid, bw_done;

    assign z_fire   = (state_q == S_FW_Z) && z_in_valid;
    assign bw_adv   = (state_q == S_BW) && (&bw_done);
    assign bw_enter = z_fire && (l_q == L_MAX);
    assign bw_next  = bw_adv && (l_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            l_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        l_q     <= '0;
                        state_q <= S_FW_REQ;
                    end
                end
                S_FW_REQ: if (layer_fw_ready) state_q <= S_FW_W;
                S_FW_W:   if (weights_valid && w_out_ready) state_q <= S_FW_Z;
                S_FW_Z: begin
                    if (z_in_valid) begin
                        if (l_q == L_MAX) begin
                            state_q <= S_BW;
                        end else begin
                            l_q     <= l_q + L_ONE;
                            state_q <= S_FW_REQ;
                        end
                    end
                end
                S_BW: begin
                    if (bw_adv) begin
                        if (l_q == '0) state_q <= S_IDLE;
                        else           l_q     <= l_q - L_ONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Buffer and target are data only; reset leaves them untouched.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && in_valid) begin
            zbuf_q[0] <= x_in;
            target_q  <= y_in;
        end
        if (z_fire) begin
            for (int i = 1; i <= LAYER_MAX + 1; i++) begin
                if (i == int'(l_q) + 1) zbuf_q[i] <= z_in;
            end
        end
    end

    always_comb begin
        z_sel  = '0;
        zp_sel = '0;
        for (int i = 0; i <= LAYER_MAX; i++) begin
            if (i == int'(l_q)) begin
                zp_sel = zbuf_q[i];
                z_sel  = zbuf_q[i+1];
            end
        end
    end

    always_comb begin
        bw_load            = {BW_STREAM_NUM{bw_enter || bw_next}};
        bw_load[BW_SAMPLE] = bw_enter;
    end

    assign bw_ready[BW_LAYER]  = layer_bw_ready;
    assign bw_ready[BW_SAMPLE] = sample_ready;
    assign bw_ready[BW_Z]      = z_ready;
    assign bw_ready[BW_ZPREV]  = z_prev_ready;

    for (genvar g = 0; g < BW_STREAM_NUM; g++) begin : g_bw
        bw_stream_reg u_stream (
            .clk     (clk),
            .rst     (rst),
            .load_i  (bw_load[g]),
            .ready_i (bw_ready[g]),
            .valid_o (bw_valid[g]),
            .done_o  (bw_done[g])
        );
    end

    assign in_ready       = (state_q == S_IDLE);
    assign busy           = (state_q != S_IDLE);
    assign layer_fw       = l_q;
    assign layer_fw_valid = (state_q == S_FW_REQ);
    assign w_out          = weights;
    assign w_out_valid    = (state_q == S_FW_W) && weights_valid;
    assign weights_ready  = (state_q == S_FW_W) && w_out_ready;
    assign z_in_ready     = (state_q == S_FW_Z);
    assign layer_bw       = l_q;
    assign layer_bw_valid = bw_valid[BW_LAYER];
    assign sample         = target_q;
    assign sample_valid   = bw_valid[BW_SAMPLE];
    assign z              = z_sel;
    assign z_valid        = bw_valid[BW_Z];
    assign z_prev         = zp_sel;
    assign z_prev_valid   = bw_valid[BW_ZPREV];

`ifdef SAMPLE_COUNT_EN
    logic [SAMPLE_COUNT_WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (bw_adv && l_q == '0) begin
            count_q <= count_q + SAMPLE_COUNT_WIDTH'(1);
        end
    end

    assign sample_count = count_q;
`endif

endmodule

// File: tb/tb_training_sequencer.sv
// Bench for training_sequencer: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_training_sequencer;

    localparam int N   = 4;
    localparam int NOW = 10;
    localparam int AW  = 9;
    localparam int WCW = 16;
    localparam int LAW = 2;
    localparam int LM  = 1;
    localparam int ZW  = N * NOW;
    localparam int SW  = N * AW;
    localparam int WW  = N * N * WCW;
    localparam logic [ZW-1:0] X_LIT = {4{10'h0AB}};
    localparam logic [SW-1:0] Y_LIT = {4{9'h155}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [ZW-1:0]  x_in = '0, z_in = '0, z, z_prev;
    logic [SW-1:0]  y_in = '0, sample;
    logic [WW-1:0]  weights = '0, w_out;
    logic [LAW-1:0] layer_fw, layer_bw;
    logic in_valid = 0, z_in_valid = 0, weights_valid = 0;
    logic layer_fw_ready = 0, w_out_ready = 0, layer_bw_ready = 0;
    logic sample_ready = 0, z_ready = 0, z_prev_ready = 0;
    logic in_ready, z_in_ready, weights_ready, layer_fw_valid, w_out_valid;
    logic layer_bw_valid, sample_valid, z_valid, z_prev_valid, busy;
`ifdef SAMPLE_COUNT_EN
    logic [15:0] sample_count;
`endif

    training_sequencer #(
        .NEURON_NUM(N), .NEURON_OUTPUT_WIDTH(NOW), .ACTIVATION_WIDTH(AW),
        .WEIGHT_CELL_WIDTH(WCW), .LAYER_ADDR_WIDTH(LAW), .LAYER_MAX(LM)
    ) dut (
        .clk(clk), .rst(rst),
        .x_in(x_in), .y_in(y_in), .in_valid(in_valid), .in_ready(in_ready),
        .z_in(z_in), .z_in_valid(z_in_valid), .z_in_ready(z_in_ready),
        .layer_fw(layer_fw), .layer_fw_valid(layer_fw_valid), .layer_fw_ready(layer_fw_ready),
        .weights(weights), .weights_valid(weights_valid), .weights_ready(weights_ready),
        .w_out(w_out), .w_out_valid(w_out_valid), .w_out_ready(w_out_ready),
        .layer_bw(layer_bw), .layer_bw_valid(layer_bw_valid), .layer_bw_ready(layer_bw_ready),
        .sample(sample), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .z(z), .z_valid(z_valid), .z_ready(z_ready),
        .z_prev(z_prev), .z_prev_valid(z_prev_valid), .z_prev_ready(z_prev_ready),
`ifdef SAMPLE_COUNT_EN
        .sample_count(sample_count),
`endif
        .busy(busy)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a sample is one input, LM+1 (request, weights, z) triples,
    // then LM+1 backward groups, last layer first, each group fully drained in turn.
    typedef struct {
        int          layer;
        logic [ZW-1:0] z;
        logic [ZW-1:0] zp;
        bit          smp;
    } grp_t;

    bit            m_busy = 0;
    int            n_req = 0, n_w = 0, n_z = 0;
    logic [ZW-1:0] m_buf [0:LM+1];
    logic [SW-1:0] m_tgt = '0;
    grp_t          grp_q[$];
    grp_t          g;
    bit            bw_live = 0, bw_arm = 0;
    bit            d_l, d_s, d_z, d_p;
    int            samples_done = 0;
    logic [15:0]   m_count = '0;
    bit            f_in = 0, f_w = 0, f_z = 0;

    int            fw_log[$];
    int            bwl_layer[$];
    bit            bwl_smp[$];
    logic [ZW-1:0] bwl_zp[$];

    always @(negedge clk) begin
        bit in_acc, e_fw, e_wph, e_zph, e_l, e_s, e_z, e_p;
        if (rst) begin
            m_busy = 0; n_req = 0; n_w = 0; n_z = 0;
            grp_q.delete(); bw_live = 0; bw_arm = 0; m_count = '0;
            f_in = 0; f_w = 0; f_z = 0;
        end else begin
            if (bw_arm) begin
                bw_live = 1; bw_arm = 0;
                d_l = 0; d_s = 0; d_z = 0; d_p = 0;
            end
            if (bw_live) g = grp_q[0];
            in_acc = !m_busy && in_valid;
            e_fw   = m_busy && n_req == n_z && n_z <= LM;
            e_wph  = m_busy && n_req == n_w + 1;
            e_zph  = m_busy && n_w == n_z + 1;
            e_l    = bw_live && !d_l;
            e_z    = bw_live && !d_z;
            e_p    = bw_live && !d_p;
            e_s    = bw_live && g.smp && !d_s;

            chk("busy", 256'(busy), 256'(m_busy));
            chk("in_ready", 256'(in_ready), 256'(!m_busy));
            chk("layer_fw_valid", 256'(layer_fw_valid), 256'(e_fw));
            if (e_fw) chk("layer_fw", 256'(layer_fw), 256'(n_req));
            chk("w_out_valid", 256'(w_out_valid), 256'(e_wph && weights_valid));
            chk("weights_ready", 256'(weights_ready), 256'(e_wph && w_out_ready));
            if (e_wph && weights_valid) chk("w_out", 256'(w_out), 256'(weights));
            chk("z_in_ready", 256'(z_in_ready), 256'(e_zph));
            chk("layer_bw_valid", 256'(layer_bw_valid), 256'(e_l));
            chk("sample_valid", 256'(sample_valid), 256'(e_s));
            chk("z_valid", 256'(z_valid), 256'(e_z));
            chk("z_prev_valid", 256'(z_prev_valid), 256'(e_p));
            if (e_l) chk("layer_bw", 256'(layer_bw), 256'(g.layer));
            if (e_s) chk("sample", 256'(sample), 256'(m_tgt));
            if (e_z) chk("z", 256'(z), 256'(g.z));
            if (e_p) chk("z_prev", 256'(z_prev), 256'(g.zp));
`ifdef SAMPLE_COUNT_EN
            chk("sample_count", 256'(sample_count), 256'(m_count));
`endif

            if (layer_fw_valid && layer_fw_ready) fw_log.push_back(int'(layer_fw));
            if (layer_bw_valid && layer_bw_ready) begin
                bwl_layer.push_back(int'(layer_bw));
                bwl_smp.push_back(sample_valid);
                bwl_zp.push_back(z_prev);
            end

            f_in = in_acc;
            f_w  = e_wph && weights_valid && w_out_ready;
            f_z  = e_zph && z_in_valid;
            if (in_acc) begin
                m_busy = 1; n_req = 0; n_w = 0; n_z = 0;
                m_buf[0] = x_in; m_tgt = y_in;
            end
            if (e_fw && layer_fw_ready) n_req++;
            if (f_w) n_w++;
            if (f_z) begin
                m_buf[n_z+1] = z_in;
                n_z++;
                if (n_z == LM + 1) begin
                    for (int l = LM; l >= 0; l--)
                        grp_q.push_back('{layer: l, z: m_buf[l+1], zp: m_buf[l], smp: (l == LM)});
                    bw_arm = 1;
                end
            end
            if (bw_live) begin
                if (e_l && layer_bw_ready) d_l = 1;
                if (e_s && sample_ready)   d_s = 1;
                if (e_z && z_ready)        d_z = 1;
                if (e_p && z_prev_ready)   d_p = 1;
                if (d_l && d_z && d_p && (d_s || !g.smp)) begin
                    void'(grp_q.pop_front());
                    bw_live = 0;
                    if (grp_q.size() > 0) bw_arm = 1;
                    else begin
                        m_busy = 0;
                        samples_done++;
                        m_count++;
                    end
                end
            end
        end
    end

    // Stimulus driver: producers hold data until accepted; consumers random or always ready.
    bit            all_ready = 1;
    int            samples_left = 0;
    bit            dir_use = 0;
    logic [ZW-1:0] dir_x;
    logic [SW-1:0] dir_y;
    bit            zin_block = 0, zhold_req = 0, whold_req = 0;
    int            zhold_left = 0, whold_left = 0;

    function automatic bit rnd_ready();
        return all_ready || ($urandom_range(0, 3) != 0);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!(in_valid && !f_in)) begin
                if (samples_left > 0 && (all_ready || $urandom_range(0, 2) == 0)) begin
                    in_valid = 1;
                    samples_left--;
                    if (dir_use) begin
                        x_in = dir_x; y_in = dir_y; dir_use = 0;
                    end else begin
                        x_in = ZW'({$urandom(), $urandom()});
                        y_in = SW'({$urandom(), $urandom()});
                    end
                end else in_valid = 0;
            end
            if (!(weights_valid && !f_w)) begin
                weights_valid = all_ready || ($urandom_range(0, 2) != 0);
                for (int i = 0; i < WW / 32; i++) weights[i*32 +: 32] = $urandom();
            end
            if (!(z_in_valid && !f_z)) begin
                z_in_valid = (zin_block && n_z == 1) ? 1'b0 : (all_ready || ($urandom_range(0, 2) != 0));
                z_in = ZW'({$urandom(), $urandom()});
            end
            layer_fw_ready = rnd_ready();
            layer_bw_ready = rnd_ready();
            sample_ready   = rnd_ready();
            z_prev_ready   = rnd_ready();
            if (whold_left > 0) begin
                w_out_ready = 0; whold_left--;
            end else if (whold_req && w_out_valid) begin
                w_out_ready = 0; whold_req = 0; whold_left = 2;
            end else w_out_ready = rnd_ready();
            if (zhold_left > 0) begin
                z_ready = 0; zhold_left--;
            end else if (zhold_req && layer_bw_valid && layer_bw == 2'd1) begin
                z_ready = 0; zhold_req = 0; zhold_left = 4;
            end else z_ready = rnd_ready();
        end
    end

    task automatic wait_done(input int target, input int budget);
        int c = 0;
        while (samples_done < target && c < budget) begin
            @(posedge clk);
            #2;
            c++;
        end
        chk("sample_completed", 256'(samples_done >= target), 256'(1));
    endtask

    task automatic clear_logs();
        fw_log.delete(); bwl_layer.delete(); bwl_smp.delete(); bwl_zp.delete();
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, "_in_ready"}, 256'(in_ready), 256'(1));
        chk({tag, "_busy"}, 256'(busy), 256'(0));
        chk({tag, "_valids"}, 256'({layer_fw_valid, w_out_valid, layer_bw_valid,
                                    sample_valid, z_valid, z_prev_valid}), 256'(0));
        chk({tag, "_z_in_ready"}, 256'(z_in_ready), 256'(0));
    endtask

    initial begin
        bit ok;
        repeat (3) @(posedge clk);
        #2 rst = 0;
        @(posedge clk);
        #2;
        idle_checks("reset");

        // Plain sample with every consumer ready.
        clear_logs();
        dir_x = X_LIT; dir_y = Y_LIT; dir_use = 1; samples_left = 1;
        wait_done(1, 200);
        chk("a_fw_count", 256'(fw_log.size()), 256'(2));
        chk("a_fw0", 256'(fw_log[0]), 256'(0));
        chk("a_fw1", 256'(fw_log[1]), 256'(1));
        chk("a_bw0_layer", 256'(bwl_layer[0]), 256'(1));
        chk("a_bw0_sample", 256'(bwl_smp[0]), 256'(1));
        chk("a_bw1_layer", 256'(bwl_layer[1]), 256'(0));
        chk("a_bw1_sample", 256'(bwl_smp[1]), 256'(0));
        chk("a_bw1_z_prev", 256'(bwl_zp[1]), 256'(X_LIT));
        chk("a_busy_after", 256'(busy), 256'(0));

        // z consumer stalls on layer 1 while the others accept.
        zhold_req = 1; samples_left = 1;
        wait_done(2, 200);

        // Neuron bank stalls the weight transfer.
        whold_req = 1; samples_left = 1;
        wait_done(3, 200);

        // Reset while waiting for layer 1 output.
        zin_block = 1; samples_left = 1; ok = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #2;
            if (z_in_ready && n_z == 1) begin
                ok = 1;
                break;
            end
        end
        chk("d_reached_fw_z_l1", 256'(ok), 256'(1));
        rst = 1;
        @(posedge clk);
        #2;
        rst = 0;
        idle_checks("d_reset");
        zin_block = 0;
        clear_logs();
        samples_left = 1;
        wait_done(4, 200);
        chk("d_fw_count", 256'(fw_log.size()), 256'(2));
        chk("d_fw0", 256'(fw_log[0]), 256'(0));
        chk("d_bw_last_layer", 256'(bwl_layer[1]), 256'(0));

        // Random valids and readies.
        all_ready = 0; samples_left = 30;
        wait_done(34, 8000);
`ifdef SAMPLE_COUNT_EN
        chk("sample_count_total", 256'(sample_count), 256'(31));
`endif
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
